// File: rtl/load_store_unit_pkg.sv
// Shared CPU definitions for the load/store unit: RV32I width codes, FSM states
// and small helpers for legality checking and store lane formatting.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    // Undefined width codes are reported through the same misaligned flag.
    function automatic logic lsu_misaligned(input logic       is_store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        if (is_store) begin
            case (funct3)
                F3_SB:   bad = 1'b0;
                F3_SH:   bad = addr_lo[0];
                F3_SW:   bad = |addr_lo;
                default: bad = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: bad = 1'b0;
                F3_LH, F3_LHU: bad = addr_lo[0];
                F3_LW:         bad = |addr_lo;
                default:       bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    function automatic logic [3:0] lsu_wstrb(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (funct3)
            F3_SB:   strb = 4'b0001 << addr_lo;
            F3_SH:   strb = 4'b0011 << addr_lo;
            F3_SW:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [2:0]  funct3,
                                              input logic [31:0] data);
        logic [31:0] wd;
        case (funct3)
            F3_SB:   wd = {4{data[7:0]}};
            F3_SH:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load byte/halfword selection and sign/zero extension of the memory read word.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = rdata[{addr[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'h000000, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'h0000, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one outstanding memory access with registered
// memory-side outputs, access timeout and misalignment reporting.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] load_data_q, load_data_d;
    logic        done_q, done_d;
    logic        misaligned_q, misaligned_d;
    logic        timeout_q, timeout_d;
    logic [31:0] aligned_rdata;

    load_align u_load_align (
        .rdata  (mem_rdata),
        .addr   (addr_lo_q),
        .funct3 (funct3_q),
        .result (aligned_rdata)
    );

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        load_data_d  = load_data_q;
        done_d       = 1'b0;
        misaligned_d = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_lo_d  = addr[1:0];
                    cnt_d      = '0;
                    if (lsu_misaligned(is_store, funct3, addr[1:0])) begin
                        state_d      = RESP;
                        done_d       = 1'b1;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wstrb_d = is_store ? lsu_wstrb(funct3, addr[1:0]) : 4'b0000;
                        mem_wdata_d = is_store ? lsu_wdata(funct3, store_data) : '0;
                    end
                end
            end
            ACCESS: begin
                // Ack in the limit cycle is checked first so it beats the timeout.
                if (mem_ack) begin
                    state_d   = RESP;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!is_store_q) begin
                        load_data_d = aligned_rdata;
                    end
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d   = RESP;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!is_store_q) begin
                        load_data_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            load_data_q  <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            load_data_q  <= load_data_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
        end
    end

    assign busy       = ((state_q == IDLE) && start) || (state_q == ACCESS);
    assign done       = done_q;
    assign load_data  = load_data_q;
    assign misaligned = misaligned_q;
    assign timeout    = timeout_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, hand-written corner
// sequences and randomized transactions checked against a behavioural model.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset, start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        busy, done, misaligned, timeout;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned),
        .timeout    (timeout),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          dly;
        logic [3:0]  strb;
        logic [31:0] wdata;
        bit          mis;
        bit          to;
        logic [31:0] ld;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: access size in bytes, 0 for an undefined code.
    function automatic int m_size(input bit st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit m_bad(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = m_size(st, f3);
        return (sz == 0) || ((a % sz) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int sz;
        logic [31:0] v;
        sz = m_size(1'b0, f3);
        v = rd >> (8 * (a % 4));
        if (sz == 4) return rd;
        v = v & ((32'd1 << (8 * sz)) - 1);
        if (!f3[2] && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 1);
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = m_size(1'b1, f3);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] r;
        case (m_size(1'b1, f3))
            1:       r = {4{sd[7:0]}};
            2:       r = {2{sd[15:0]}};
            default: r = sd;
        endcase
        return r;
    endfunction

    // One complete transaction; dly is the ACCESS cycle index of the ack, dly>=TO never acks.
    task automatic run_txn(input string nm, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                           input int dly, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                           input bit e_mis, input bit e_to, input logic [31:0] e_ld);
        int k;
        bit acked;
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        #1;
        chk({nm, "_busy_start"}, 32'(busy), 32'd1);
        chk({nm, "_req_start"}, 32'(mem_req), 32'd0);
        @(negedge clk);
        start = 1'b0; addr = $urandom; store_data = $urandom;
        if (e_mis) begin
            chk({nm, "_done"}, 32'(done), 32'd1);
            chk({nm, "_misaligned"}, 32'(misaligned), 32'd1);
            chk({nm, "_timeout"}, 32'(timeout), 32'd0);
            chk({nm, "_req"}, 32'(mem_req), 32'd0);
            chk({nm, "_busy_resp"}, 32'(busy), 32'd0);
            chk({nm, "_load_data"}, load_data, e_ld);
        end else begin
            k = 0;
            acked = 1'b0;
            while (!acked && k < TO) begin
                chk({nm, "_req"}, 32'(mem_req), 32'd1);
                chk({nm, "_addr"}, mem_addr, {a[31:2], 2'b00});
                chk({nm, "_we"}, 32'(mem_we), 32'(st));
                chk({nm, "_wstrb"}, 32'(mem_wstrb), 32'(e_strb));
                if (st) chk({nm, "_wdata"}, mem_wdata, e_wdata);
                chk({nm, "_busy_access"}, 32'(busy), 32'd1);
                chk({nm, "_done_early"}, 32'(done), 32'd0);
                if (k == dly) begin
                    mem_ack = 1'b1; mem_rdata = rd; acked = 1'b1;
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom;
                end
                @(negedge clk);
                k++;
            end
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            chk({nm, "_done"}, 32'(done), 32'd1);
            chk({nm, "_misaligned"}, 32'(misaligned), 32'd0);
            chk({nm, "_timeout"}, 32'(timeout), 32'(e_to));
            chk({nm, "_req_resp"}, 32'(mem_req), 32'd0);
            chk({nm, "_busy_resp"}, 32'(busy), 32'd0);
            chk({nm, "_load_data"}, load_data, e_ld);
        end
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        chk({nm, "_req_idle"}, 32'(mem_req), 32'd0);
        chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    vec_t vt[18];
    logic [31:0] model_ld;

    initial begin
        reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0;
        store_data = '0; mem_ack = 1'b0; mem_rdata = '0;

        vt[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        2,  4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 3'd0, 32'h103, 32'h0,        32'h80FF1234, 0,  4'b0000, 32'h0,        1'b0, 1'b0, 32'hFFFFFF80};
        vt[2]  = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h80FF1234, 1,  4'b0000, 32'h0,        1'b0, 1'b0, 32'h00000080};
        vt[3]  = '{1'b1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0,        0,  4'b1100, 32'hABCDABCD, 1'b0, 1'b0, 32'h00000080};
        vt[4]  = '{1'b0, 3'd2, 32'h102, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        1'b1, 1'b0, 32'h00000080};
        vt[5]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h80FF1234, 3,  4'b0000, 32'h0,        1'b0, 1'b0, 32'hFFFF80FF};
        vt[6]  = '{1'b0, 3'd5, 32'h100, 32'h0,        32'h80FF1234, 0,  4'b0000, 32'h0,        1'b0, 1'b0, 32'h00001234};
        vt[7]  = '{1'b1, 3'd0, 32'h101, 32'h000000A5, 32'h0,        1,  4'b0010, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h00001234};
        vt[8]  = '{1'b0, 3'd1, 32'h101, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        1'b1, 1'b0, 32'h00001234};
        vt[9]  = '{1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        1'b1, 1'b0, 32'h00001234};
        vt[10] = '{1'b1, 3'd4, 32'h100, 32'h5,        32'h0,        0,  4'b0000, 32'h0,        1'b1, 1'b0, 32'h00001234};
        vt[11] = '{1'b0, 3'd0, 32'h101, 32'h0,        32'h00007F00, 15, 4'b0000, 32'h0,        1'b0, 1'b0, 32'h0000007F};
        vt[12] = '{1'b0, 3'd2, 32'h200, 32'h0,        32'h0,        TO, 4'b0000, 32'h0,        1'b0, 1'b1, 32'h0};
        vt[13] = '{1'b0, 3'd2, 32'h300, 32'h0,        32'h12345678, 1,  4'b0000, 32'h0,        1'b0, 1'b0, 32'h12345678};
        vt[14] = '{1'b1, 3'd2, 32'h204, 32'h55AA55AA, 32'h0,        TO, 4'b1111, 32'h55AA55AA, 1'b0, 1'b1, 32'h12345678};
        vt[15] = '{1'b0, 3'd2, 32'h104, 32'h0,        32'hCAFEF00D, 0,  4'b0000, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D};
        vt[16] = '{1'b1, 3'd0, 32'h103, 32'h12345677, 32'h0,        0,  4'b1000, 32'h77777777, 1'b0, 1'b0, 32'hCAFEF00D};
        vt[17] = '{1'b1, 3'd1, 32'h100, 32'h9999BEEF, 32'h0,        2,  4'b0011, 32'hBEEFBEEF, 1'b0, 1'b0, 32'hCAFEF00D};

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        foreach (vt[i]) begin
            run_txn($sformatf("vec%0d", i), vt[i].st, vt[i].f3, vt[i].a, vt[i].sd, vt[i].rd,
                    vt[i].dly, vt[i].strb, vt[i].wdata, vt[i].mis, vt[i].to, vt[i].ld);
        end

        // Ack while idle must be ignored.
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;
        repeat (2) begin
            @(negedge clk);
            chk("idle_ack_done", 32'(done), 32'd0);
            chk("idle_ack_req", 32'(mem_req), 32'd0);
            chk("idle_ack_ld", load_data, 32'hCAFEF00D);
        end
        mem_ack = 1'b0;

        // start held during ACCESS and RESP is not queued.
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h400; store_data = 32'h11111111;
        @(negedge clk);
        is_store = 1'b0; addr = 32'h800;
        chk("ign_addr0", mem_addr, 32'h400);
        #1 chk("ign_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ign_addr1", mem_addr, 32'h400);
        chk("ign_we1", 32'(mem_we), 32'd1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_busy_resp", 32'(busy), 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk("ign_no_requeue_req", 32'(mem_req), 32'd0);
        chk("ign_no_requeue_done", 32'(done), 32'd0);

        // Reset in the third ACCESS cycle aborts silently.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h100;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rma_req_before", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rma_req", 32'(mem_req), 32'd0);
        chk("rma_busy", 32'(busy), 32'd0);
        chk("rma_done", 32'(done), 32'd0);
        chk("rma_ld", load_data, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rma_no_done", 32'(done), 32'd0);
            chk("rma_no_req", 32'(mem_req), 32'd0);
        end
        run_txn("rma_after", 1'b0, 3'd2, 32'h100, 32'h0, 32'hA5A50001, 1,
                4'b0000, 32'h0, 1'b0, 1'b0, 32'hA5A50001);

        model_ld = 32'hA5A50001;
        for (int n = 0; n < 40; n++) begin
            bit          st, bad, to;
            logic [2:0]  f3;
            logic [31:0] a, sd, rd;
            int          dly, pick;
            st   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            sd   = $urandom;
            rd   = $urandom;
            pick = $urandom_range(0, 9);
            dly  = (pick == 0) ? TO : (pick == 1) ? TO - 1 : $urandom_range(0, 4);
            bad  = m_bad(st, f3, a);
            to   = !bad && (dly >= TO);
            if (!bad && !st) model_ld = to ? 32'h0 : m_load(f3, a, rd);
            run_txn($sformatf("rnd%0d", n), st, f3, a, sd, rd, dly,
                    (st && !bad) ? m_strb(f3, a) : 4'b0000,
                    m_wdata(f3, sd), bad, to, model_ld);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
